mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, variable-latency memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (load/store fed by the EX/MEM pipeline register).
//  Sequences every access with a req/ready handshake and drives per-requester stall and done signals.
//  MEM stage has fixed priority over IF, because it holds the older instruction.
// PARAMETERS
//  ADDR_W          16   memory word-address width
//  DATA_W          32   memory data width; IF and MEM share it
//  TIMEOUT_CYCLES  64   max cycles mem_req may wait for mem_ready (only with MEMARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_rd      in   1       IF fetch request; held stable while if_stall=1
//  if_addr    in   ADDR_W  fetch address
//  if_stall   out  1       IF must hold its request and PC
//  if_done    out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched word, registered
//  dm_rd      in   1       MEM-stage load (EX/MEM MEM_read)
//  dm_wr      in   1       MEM-stage store (EX/MEM MEM_write)
//  dm_addr    in   ADDR_W  EX/MEM ALU result
//  dm_wdata   in   DATA_W  EX/MEM RF_out2
//  dm_stall   out  1       freezes the pipeline from the MEM stage backwards
//  dm_done    out  1       1-cycle pulse: access complete, dm_rdata valid for loads
//  dm_rdata   out  DATA_W  loaded word, registered
//  mem_req    out  1       memory request; held high until mem_ready is sampled
//  mem_we     out  1       1 = write
//  mem_addr   out  ADDR_W  registered address
//  mem_wdata  out  DATA_W  registered write data
//  mem_rdata  in   DATA_W  valid when mem_ready=1
//  mem_ready  in   1       access complete this cycle
//  arb_err    out  1       sticky timeout flag (always 0 without MEMARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, any in-flight access abandoned (mem_req drops immediately).
//  FSM: IDLE -> DM_BUSY | IF_BUSY -> DONE -> IDLE.
//  IDLE: dm_rd|dm_wr sampled high -> latch mem_addr/mem_we/mem_wdata, go to DM_BUSY.
//    Otherwise, if_rd high -> latch if_addr with mem_we=0, go to IF_BUSY.
//  *_BUSY: mem_req=1 and mem_* outputs held stable; mem_ready=1 at an edge -> latch mem_rdata into
//    dm_rdata or if_rdata, go to DONE.
//  DONE (one cycle): the matching *_done=1; its stall=0; no new grant is made this cycle, because
//    the requester's inputs still show the completed request.
//  Stalls: dm_stall = (dm_rd|dm_wr) & ~dm_done; if_stall = if_rd & ~if_done. Both are combinational.
//  Latency: request at edge N, mem_req high N+1..M, done pulse in cycle M+1. Zero-wait memory gives
//    3 cycles per access.
//  Stores: dm_rdata is unchanged. dm_rd & dm_wr both high is treated as a write.
//  A request arriving while the other requester is BUSY waits; it is never pre-empted.
//  IF can starve only while back-to-back MEM accesses occur; this is accepted.
//  Requests dropped mid-BUSY, e.g. by a flush, still complete; the done pulse is ignored.
// CONFIGURATION
//  MEMARB_TIMEOUT_EN defined: a counter runs in *_BUSY. When it reaches TIMEOUT_CYCLES with no
//    mem_ready, the access is aborted: mem_req=0, go to DONE, rdata=0, arb_err set until rst.
//  MEMARB_TIMEOUT_EN undefined: no counter, arb_err tied 0, and BUSY waits forever.
// STRUCTURE
//  mem_arb_pkg: state enum {IDLE, DM_BUSY, IF_BUSY, DONE}; grant enum {GNT_NONE, GNT_DM, GNT_IF}.
//  Sub-module mem_arb_timeout, a cleared/enabled counter with expiry flag, exists only under
//  MEMARB_TIMEOUT_EN. The FSM and datapath registers stay in the top module.
// TESTING
//  1. Load, dm_addr=0x0010, mem_ready 2 cycles after mem_req, mem_rdata=0xDEADBEEF
//     -> dm_done pulses once, dm_rdata=0xDEADBEEF, dm_stall high until the done cycle.
//  2. Store, dm_addr=0x0020, dm_wdata=0x12345678, zero-wait
//     -> mem_we=1 with stable addr/data while mem_req=1, dm_done 3 cycles after request, dm_rdata unchanged.
//  3. if_rd and dm_rd raised in the same cycle
//     -> DM granted first, IF granted the cycle after dm_done, if_stall high throughout.
//  4. dm_rd raised while IF_BUSY (mem_ready delayed 5 cycles)
//     -> IF completes, then DM is granted, and mem_addr never changes while mem_req=1.
//  5. rst asserted mid-DM_BUSY -> mem_req, dm_stall and dm_done go 0 immediately, state IDLE,
//     and a fresh request after rst completes normally.
//  6. MEMARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> abort after 8 cycles,
//     dm_done pulse, dm_rdata=0, arb_err=1 until rst.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the IF/MEM memory-port arbiter: the FSM state
//               encoding, the grant owner encoding and a small state helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Arbiter FSM: IDLE -> DM_BUSY | IF_BUSY -> DONE -> IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Owner of the access currently in flight
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DM   = 2'd1,
    GNT_IF   = 2'd2
  } grant_e;

  // True while a memory access is outstanding
  function automatic logic is_busy(input arb_state_e s);
    return (s == DM_BUSY) || (s == IF_BUSY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_timeout.sv
// ============================================================================
// Module      : mem_arb_timeout
// Description : Clearable, enabled cycle counter with an expiry flag. Used by
//               mem_port_arbiter to abort memory accesses that never complete.
//               Only present when MEMARB_TIMEOUT_EN is defined.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               clr_i     - synchronous clear (counter back to 0)
//               en_i      - count enable
//               expired_o - high in the LIMIT-th consecutive enabled cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MEMARB_TIMEOUT_EN
module mem_arb_timeout #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Counter only has to reach LIMIT-1, so clog2(LIMIT) bits are enough
  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt_q;

  // Expiry is flagged in the cycle that would complete the LIMIT-th count,
  // so the owner aborts after exactly LIMIT enabled cycles.
  assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, variable-latency memory between the
//               IF stage (read-only fetch) and the MEM stage (load/store).
//               MEM has fixed priority over IF since it holds the older
//               instruction. Each access runs a req/ready handshake and ends
//               with a one-cycle done pulse to the owning requester.
// Build macro : MEMARB_TIMEOUT_EN - enables the access timeout (sticky
//               arb_err_o, abort after TIMEOUT_CYCLES busy cycles). Without
//               it BUSY waits forever and arb_err_o stays 0.
// Ports       : clk, rst                      - clock / async active-high reset
//               if_rd_i, if_addr_i            - fetch request
//               if_stall_o, if_done_o, if_rdata_o - fetch status / data
//               dm_rd_i, dm_wr_i, dm_addr_i, dm_wdata_i - load/store request
//               dm_stall_o, dm_done_o, dm_rdata_o - MEM status / load data
//               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o - memory request
//               mem_rdata_i, mem_ready_i      - memory response
//               arb_err_o                     - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  // IF stage
  input  logic              if_rd_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_stall_o,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // MEM stage
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_stall_o,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  // Memory
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  // Status
  output logic              arb_err_o
);

  arb_state_e        state_q;
  grant_e            grant_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              dm_done_q;
  logic              if_done_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              arb_err_q;

  logic              dm_req;
  logic              timeout;

  assign dm_req = dm_rd_i | dm_wr_i;

`ifdef MEMARB_TIMEOUT_EN
  logic busy;
  assign busy = is_busy(state_q);

  // Counts only cycles still waiting on mem_ready; cleared outside BUSY
  mem_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .en_i      (busy && !mem_ready_i),
    .expired_o (timeout)
  );
`else
  // Parameter kept in the interface so both builds share one instantiation
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout               = 1'b0;
`endif

  // Stalls are combinational so a requester is released in its done cycle.
  // Gating with rst makes them drop the instant reset is applied.
  assign dm_stall_o = dm_req  && !dm_done_q && !rst;
  assign if_stall_o = if_rd_i && !if_done_q && !rst;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign dm_done_o   = dm_done_q;
  assign if_done_o   = if_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign arb_err_o   = arb_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dm_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
      arb_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dm_req) begin
            // Simultaneous rd and wr resolves to a write
            state_q     <= DM_BUSY;
            grant_q     <= GNT_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_wr_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (if_rd_i) begin
            state_q    <= IF_BUSY;
            grant_q    <= GNT_IF;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
          end
        end

        DM_BUSY, IF_BUSY: begin
          // mem_ready has priority over an expiring timeout in the same cycle
          if (mem_ready_i || timeout) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (grant_q == GNT_DM) begin
              dm_done_q <= 1'b1;
              if (!mem_we_q) begin
                dm_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
              end
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
            end
            if (!mem_ready_i) begin
              arb_err_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // Requester inputs still show the finished request: no grant here
          state_q   <= IDLE;
          grant_q   <= GNT_NONE;
          dm_done_q <= 1'b0;
          if_done_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
